// File: rtl/pipe_adder_acc.sv
// Two-stage unsigned adder with an optional saturating accumulator.
// Stage p1 holds the exact pair sum; stage p2 holds the result and accumulator.
module pipe_adder_acc #(
  parameter int WIDTH   = 8,
  parameter int ACC_EXT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     mode,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH+ACC_EXT:0]   sum,
  output logic                     ovf
);

  localparam int SW = WIDTH + 1;
  localparam int AW = WIDTH + 1 + ACC_EXT;

  // Returns {saturated, value}; value is all-ones whenever the add carries out.
  function automatic logic [AW:0] sat_add(input logic [AW-1:0] acc,
                                          input logic [SW-1:0] s);
    logic [AW:0] full;
    full = {1'b0, acc} + {{(AW + 1 - SW){1'b0}}, s};
    if (full[AW]) sat_add = {1'b1, {AW{1'b1}}};
    else          sat_add = full;
  endfunction

  logic          vld_p1_q, vld_p1_d;
  logic [SW-1:0] sum_p1_q, sum_p1_d;
  logic          mode_p1_q, mode_p1_d;
  logic          clr_p1_q, clr_p1_d;
  logic          vld_p2_q, vld_p2_d;
  logic [AW-1:0] sum_p2_q, sum_p2_d;
  logic [AW-1:0] acc_p2_q, acc_p2_d;
  logic          ovf_p2_q, ovf_p2_d;
  logic [AW:0]   acc_sat;
  logic          take_p1, adv_p2;

  assign in_ready  = !rst && (!vld_p1_q || !vld_p2_q || out_ready);
  assign take_p1   = in_valid && in_ready;
  assign adv_p2    = vld_p1_q && (!vld_p2_q || out_ready);
  assign acc_sat   = sat_add(acc_p2_q, sum_p1_q);
  assign out_valid = vld_p2_q;
  assign sum       = sum_p2_q;
  assign ovf       = ovf_p2_q;

  always_comb begin
    vld_p1_d  = vld_p1_q;
    sum_p1_d  = sum_p1_q;
    mode_p1_d = mode_p1_q;
    clr_p1_d  = clr_p1_q;
    vld_p2_d  = vld_p2_q;
    sum_p2_d  = sum_p2_q;
    acc_p2_d  = acc_p2_q;
    ovf_p2_d  = ovf_p2_q;

    // Stage p1: capture the exact pair sum, or empty when it moves on
    if (take_p1) begin
      vld_p1_d  = 1'b1;
      sum_p1_d  = {1'b0, a} + {1'b0, b};
      mode_p1_d = mode;
      clr_p1_d  = clr;
    end else if (adv_p2) begin
      vld_p1_d  = 1'b0;
    end

    // Stage p2: the accumulator moves only when a beat enters this stage
    if (adv_p2) begin
      vld_p2_d = 1'b1;
      if (mode_p1_q) begin
        if (clr_p1_q) begin
          acc_p2_d = {{(AW - SW){1'b0}}, sum_p1_q};
          ovf_p2_d = 1'b0;
        end else begin
          acc_p2_d = acc_sat[AW-1:0];
          ovf_p2_d = ovf_p2_q | acc_sat[AW];
        end
        sum_p2_d = acc_p2_d;
      end else begin
        sum_p2_d = {{(AW - SW){1'b0}}, sum_p1_q};
      end
    end else if (out_ready) begin
      vld_p2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      sum_p1_q  <= '0;
      mode_p1_q <= 1'b0;
      clr_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      sum_p2_q  <= '0;
      acc_p2_q  <= '0;
      ovf_p2_q  <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      sum_p1_q  <= sum_p1_d;
      mode_p1_q <= mode_p1_d;
      clr_p1_q  <= clr_p1_d;
      vld_p2_q  <= vld_p2_d;
      sum_p2_q  <= sum_p2_d;
      acc_p2_q  <= acc_p2_d;
      ovf_p2_q  <= ovf_p2_d;
    end
  end

endmodule

// File: tb/tb_pipe_adder_acc.sv
// Directed bench: a wide (ACC_EXT=4) and a narrow (ACC_EXT=0) instance share one stimulus stream.
module tb_pipe_adder_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        mode = 1'b0;
  logic        clr = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready4, out_valid4, ovf4;
  logic [12:0] sum4;
  logic        in_ready0, out_valid0, ovf0;
  logic [8:0]  sum0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_adder_acc #(.WIDTH(8), .ACC_EXT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .mode(mode), .clr(clr),
    .out_valid(out_valid4), .out_ready(out_ready), .sum(sum4), .ovf(ovf4)
  );

  pipe_adder_acc #(.WIDTH(8), .ACC_EXT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .mode(mode), .clr(clr),
    .out_valid(out_valid0), .out_ready(out_ready), .sum(sum0), .ovf(ovf0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One isolated beat with out_ready high; checks latency and both results.
  task automatic beat(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tm, input logic tc,
                      input int e4, input logic eo4, input int e0, input logic eo0);
    @(negedge clk);
    a = ta; b = tb; mode = tm; clr = tc; in_valid = 1'b1;
    #1 chk({tag, ".in_ready"}, 64'(in_ready4), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".lat1"}, 64'(out_valid4), 64'd0);
    @(negedge clk);
    chk({tag, ".valid4"}, 64'(out_valid4), 64'd1);
    chk({tag, ".sum4"}, 64'(sum4), 64'(e4));
    chk({tag, ".ovf4"}, 64'(ovf4), 64'(eo4));
    chk({tag, ".valid0"}, 64'(out_valid0), 64'd1);
    chk({tag, ".sum0"}, 64'(sum0), 64'(e0));
    chk({tag, ".ovf0"}, 64'(ovf0), 64'(eo0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, got, first_block;
    logic [12:0] held;
    logic holding, accept;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.in_ready", 64'(in_ready4), 64'd0);
    chk("rst.out_valid", 64'(out_valid4), 64'd0);
    chk("rst.sum", 64'(sum4), 64'd0);
    chk("rst.ovf", 64'(ovf4), 64'd0);
    rst = 1'b0;
    #1 chk("rst.release_ready", 64'(in_ready4), 64'd1);

    // Pair-add corner case, 9-bit exact on both widths
    beat("pair", 8'd255, 8'd255, 1'b0, 1'b0, 510, 1'b0, 510, 1'b0);

    // Accumulation; the narrow instance saturates on the third beat
    beat("acc1", 8'd10,  8'd20,  1'b1, 1'b1, 30,  1'b0, 30,  1'b0);
    beat("acc2", 8'd100, 8'd100, 1'b1, 1'b0, 230, 1'b0, 230, 1'b0);
    beat("acc3", 8'd255, 8'd255, 1'b1, 1'b0, 740, 1'b0, 511, 1'b1);

    // Saturation boundary
    beat("sat1", 8'd255, 8'd255, 1'b1, 1'b1, 510, 1'b0, 510, 1'b0);
    beat("sat2", 8'd1,   8'd0,   1'b1, 1'b0, 511, 1'b0, 511, 1'b0);
    beat("sat3", 8'd1,   8'd0,   1'b1, 1'b0, 512, 1'b0, 511, 1'b1);

    // Sticky flag survives a mode-0 beat, clears on a clr beat
    beat("stk1", 8'd1, 8'd1, 1'b0, 1'b0, 2, 1'b0, 2, 1'b1);
    beat("stk2", 8'd3, 8'd4, 1'b1, 1'b1, 7, 1'b0, 7, 1'b0);

    // Backpressure: six back-to-back beats, out_ready low for 4 cycles
    k = 0; got = 0; first_block = -1; holding = 1'b0; held = '0;
    mode = 1'b0; clr = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      if (k < 6) begin
        in_valid = 1'b1; a = 8'(k * 10 + 1); b = 8'(k);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready4 && first_block < 0) first_block = k;
      if (out_valid4 && !out_ready) begin
        if (holding) chk("bp.hold", 64'(sum4), 64'(held));
        held = sum4; holding = 1'b1;
      end else begin
        holding = 1'b0;
      end
      if (out_valid4 && out_ready) begin
        chk($sformatf("bp.out%0d", got), 64'(sum4), 64'(11 * got + 1));
        got++;
      end
      accept = in_valid && in_ready4;
      @(posedge clk);
      if (accept) k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp.block_after", 64'(first_block), 64'd2);
    chk("bp.received", 64'(got), 64'd6);
    chk("bp.accepted", 64'(k), 64'd6);
    @(negedge clk);
    chk("bp.drained", 64'(out_valid4), 64'd0);

    // Arm the sticky flag on the narrow instance so reset has something to clear
    beat("pre1", 8'd255, 8'd255, 1'b1, 1'b1, 510,  1'b0, 510, 1'b0);
    beat("pre2", 8'd255, 8'd255, 1'b1, 1'b0, 1020, 1'b0, 511, 1'b1);

    // Reset with both stages full
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; mode = 1'b0; clr = 1'b0; a = 8'd5; b = 8'd5;
    @(negedge clk);
    a = 8'd6; b = 8'd6;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid.full_valid", 64'(out_valid4), 64'd1);
    chk("mid.full_ready", 64'(in_ready4), 64'd0);
    rst = 1'b1;
    #1;
    chk("mid.valid", 64'(out_valid4), 64'd0);
    chk("mid.sum", 64'(sum4), 64'd0);
    chk("mid.ready", 64'(in_ready4), 64'd0);
    chk("mid.ovf0", 64'(ovf0), 64'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("mid.rel_ready", 64'(in_ready4), 64'd1);
    chk("mid.rel_valid", 64'(out_valid4), 64'd0);
    beat("post", 8'd1, 8'd2, 1'b0, 1'b0, 3, 1'b0, 3, 1'b0);
    @(negedge clk);
    chk("post.no_stale", 64'(out_valid4), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_adder_acc.md
PIPE_ADDER_ACC -- requirements
Module: pipe_adder_acc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal 2..64).
REQ-002 The block SHALL have parameter ACC_EXT, default 4, giving the accumulator extension bits above WIDTH+1 (legal 0..16).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Ports SHALL be, clock and reset first, in this order:
 clk        input   1                 rising-edge clock
 rst        input   1                 asynchronous active-high reset
 in_valid   input   1                 input beat valid
 in_ready   output  1                 block can accept a beat
 a          input   WIDTH             operand A, unsigned
 b          input   WIDTH             operand B, unsigned
 mode       input   1                 0 = pair add, 1 = accumulate
 clr        input   1                 beat restarts the accumulator (mode 1 only)
 out_valid  output  1                 result valid
 out_ready  input   1                 downstream accepts the result
 sum        output  WIDTH+1+ACC_EXT   result, zero-extended
 ovf        output  1                 accumulator saturated (sticky)

Function
REQ-005 A beat SHALL transfer on a rising clk edge when in_valid and in_ready are both 1; a, b, mode and clr are sampled together.
REQ-006 Result transfer SHALL occur on an edge where out_valid and out_ready are both 1.
REQ-007 Stage 1 SHALL register the exact unsigned sum a+b at WIDTH+1 bits, with no truncation, plus the mode and clr of that beat.
REQ-008 Stage 2 SHALL produce the result: in mode 0, sum equals the zero-extended stage-1 sum and the accumulator is unchanged.
REQ-009 In mode 1 with clr=1, the accumulator SHALL load the stage-1 sum, ovf SHALL clear, and sum SHALL equal the new accumulator value.
REQ-010 In mode 1 with clr=0, the accumulator SHALL become acc plus the stage-1 sum, and sum SHALL equal the new accumulator value.
REQ-011 If the mode-1 addition exceeds 2^(WIDTH+1+ACC_EXT)-1, the accumulator SHALL saturate to all-ones and ovf SHALL be set.
REQ-012 ovf SHALL stay set until a mode-1 beat with clr=1 reaches stage 2, or until reset.
REQ-013 Latency SHALL be 2 cycles from input acceptance to out_valid=1, provided there is no backpressure.
REQ-014 Throughput SHALL be one beat per cycle when out_ready is held at 1.
REQ-015 in_ready SHALL be 0 only when stage 1 holds data and stage 2 holds an unaccepted result (out_valid=1, out_ready=0).
REQ-016 in_ready SHALL be 1 when stage 1 is empty or stage 2 is draining or empty; this is a combinational function of pipeline state and out_ready.
REQ-017 While out_valid=1 and out_ready=0, sum and ovf SHALL hold stable.
REQ-018 While out_valid=1 and out_ready=0, the accumulator SHALL not update, and no beat SHALL be lost or duplicated.
REQ-019 If a stage-2 result is accepted while stage 1 is full in the same cycle, stage 1 SHALL advance into stage 2 on that edge.
REQ-020 If a stage-2 result is accepted and a new beat is accepted in the same cycle, the new beat SHALL enter stage 1 on that same edge.
REQ-021 Beats with different mode values SHALL be freely interleaved, and each beat's result SHALL follow that beat's own mode.
REQ-022 Accumulator updates SHALL occur exactly once per mode-1 beat, at the edge where that beat enters stage 2.
REQ-023 When WIDTH=8 and ACC_EXT=0, sum SHALL be 9 bits and the mode-0 behaviour SHALL be the exact 9-bit sum of two 8-bit operands.

Reset
REQ-024 Asserting rst SHALL immediately, without waiting for a clock edge, force out_valid=0, ovf=0, sum=0, the accumulator to 0 and both stage-valid flags to 0.
REQ-025 During rst, in_ready SHALL be 0, and it SHALL be 1 on the first cycle after rst deasserts.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight beats, and no result SHALL be emitted for them.

Verification
REQ-027 Pair-add corner case: WIDTH=8, mode 0, a=255, b=255, out_ready=1 -> sum=510 (0x1FE) two cycles later, ovf=0.
REQ-028 Accumulate: WIDTH=8, ACC_EXT=4, mode 1, beats (clr=1, 10+20), (0, 100+100), (0, 255+255) -> sum=30, 230, 740; ovf=0.
REQ-029 Saturation: WIDTH=8, ACC_EXT=0, mode 1, clr=1 beat 255+255, then 1+0 -> sum=510, then 511 with ovf=0, then a further 1+0 -> sum=511, ovf=1.
REQ-030 Sticky flag: after the saturation above, a mode-0 beat 1+1 -> sum=2 with ovf still 1; then a mode-1 clr=1 beat 3+4 -> sum=7, ovf=0.
REQ-031 Backpressure: 6 back-to-back mode-0 beats with out_ready held 0 for 4 cycles -> in_ready drops after 2 accepted beats, sum holds stable, and all 6 results arrive in order with none lost.
REQ-032 Reset mid-stream: rst asserted with both stages full -> out_valid=0 and sum=0 immediately; after release, first beat 1+2 -> sum=3 with no stale output.
